// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, state codes and field widths shared by the multicycle control unit.
package mc_pkg;
  localparam int STATE_W = 5;
  localparam int FN_W = 3;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_LOAD = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BR = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [STATE_W-1:0] S_FETCH = 5'd0;
  localparam logic [STATE_W-1:0] S_FWAIT = 5'd1;
  localparam logic [STATE_W-1:0] S_DECODE = 5'd2;
  localparam logic [STATE_W-1:0] S_EXEC = 5'd3;
  localparam logic [STATE_W-1:0] S_WB = 5'd4;
  localparam logic [STATE_W-1:0] S_MADDR = 5'd5;
  localparam logic [STATE_W-1:0] S_MRD = 5'd6;
  localparam logic [STATE_W-1:0] S_WBM = 5'd7;
  localparam logic [STATE_W-1:0] S_MWR = 5'd8;
  localparam logic [STATE_W-1:0] S_BRANCH = 5'd9;
  localparam logic [STATE_W-1:0] S_STEP = 5'd10;
  localparam logic [STATE_W-1:0] S_HALT = 5'd11;
endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: control unit <-> datapath/memory/debug signal bundle.
interface mc_control_unit_if
  import mc_pkg::*;
#(parameter int IR_W = 16, parameter int CNT_W = 16);
  logic [IR_W-1:0] ir;
  logic flag, mem_ack, step_en, step_go;
  logic ld_mar, ld_ir, ld_pc, ld_mdr, ld_reg, pc_inc;
  logic t_pc, t_reg, t_alu, t_mdr, t_label;
  logic mem_read, mem_write;
  logic [FN_W-1:0] fn_sel;
  logic [STATE_W-1:0] state;
  logic halted, illegal, bus_err;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input ir, flag, mem_ack, step_en, step_go,
    output ld_mar, ld_ir, ld_pc, ld_mdr, ld_reg, pc_inc, t_pc, t_reg, t_alu, t_mdr, t_label,
    output mem_read, mem_write, fn_sel, state, halted, illegal, bus_err, instr_count
  );
  modport slave (
    output ir, flag, mem_ack, step_en, step_go,
    input ld_mar, ld_ir, ld_pc, ld_mdr, ld_reg, pc_inc, t_pc, t_reg, t_alu, t_mdr, t_label,
    input mem_read, mem_write, fn_sel, state, halted, illegal, bus_err, instr_count
  );
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts memory wait cycles; expired flags the last permitted wait cycle.
module mc_wait_timer #(parameter int MEM_TIMEOUT = 15) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge Clk) cnt_q <= !Reset ? '0 : cnt_d;
  assign expired = en && cnt_q == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle CPU sequencer with memory-wait timeout, single-step and retire counter.
module mc_control_unit
  import mc_pkg::*;
#(parameter int IR_W = 16, parameter int CNT_W = 16, parameter int MEM_TIMEOUT = 15) (
  input logic Clk,
  input logic Reset,
  mc_control_unit_if.master bus
);
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic [3:0] op;
  logic in_wait, expired, timeout, retire, take, fetch_ack;
  assign op = bus.ir[IR_W-1 -: 4];
  assign in_wait = state_q == S_FWAIT || state_q == S_MRD || state_q == S_MWR;
  assign timeout = expired && !bus.mem_ack;
  assign take = op == OP_JMP || bus.flag;
  assign fetch_ack = state_q == S_FWAIT && bus.mem_ack;
  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .Clk(Clk), .Reset(Reset), .clr(!in_wait), .en(in_wait), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    retire = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: state_d = bus.mem_ack ? S_DECODE : timeout ? S_HALT : S_FWAIT;
      S_DECODE:
        case (op)
          OP_NOP: retire = 1'b1;
          OP_ALU: state_d = S_EXEC;
          OP_LOAD, OP_STORE: state_d = S_MADDR;
          OP_BR, OP_JMP: state_d = S_BRANCH;
          OP_HALT: state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      S_EXEC: state_d = S_WB;
      S_WB, S_WBM, S_BRANCH: retire = 1'b1;
      S_MADDR: state_d = op == OP_LOAD ? S_MRD : S_MWR;
      S_MRD: state_d = bus.mem_ack ? S_WBM : timeout ? S_HALT : S_MRD;
      S_MWR: begin
        retire = bus.mem_ack;
        state_d = timeout ? S_HALT : S_MWR;
      end
      S_STEP: state_d = (bus.step_go || !bus.step_en) ? S_FETCH : S_STEP;
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (retire) state_d = bus.step_en ? S_STEP : S_FETCH;
    // timeout is already gated to wait states and loses to a same-cycle ack
    bus_err_d = bus_err_q | timeout;
    cnt_d = cnt_q + CNT_W'(retire);
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      cnt_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus.ld_mar = state_q == S_FETCH || state_q == S_MADDR;
  assign bus.ld_ir = fetch_ack;
  assign bus.pc_inc = fetch_ack;
  assign bus.ld_pc = fetch_ack || (state_q == S_BRANCH && take);
  assign bus.ld_mdr = state_q == S_MRD && bus.mem_ack;
  assign bus.ld_reg = state_q == S_WB || state_q == S_WBM;
  assign bus.t_pc = state_q == S_FETCH;
  assign bus.t_reg = state_q == S_EXEC || state_q == S_MADDR || state_q == S_MWR;
  assign bus.t_alu = state_q == S_WB;
  assign bus.t_mdr = state_q == S_WBM;
  assign bus.t_label = state_q == S_BRANCH && take;
  assign bus.mem_read = state_q == S_FWAIT || state_q == S_MRD;
  assign bus.mem_write = state_q == S_MWR;
  assign bus.fn_sel = (state_q == S_EXEC || state_q == S_WB) ? bus.ir[2:0] : '0;
  assign bus.state = state_q;
  assign bus.halted = state_q == S_HALT;
  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized instruction stream checked against a per-instruction cost model.
module tb_mc_control_unit;
  import mc_pkg::*;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mc_control_unit_if #(.IR_W(16), .CNT_W(CW)) bus ();
  mc_control_unit #(.IR_W(16), .CNT_W(CW), .MEM_TIMEOUT(15)) dut (
    .Clk(clk), .Reset(rst_n), .bus(bus.master)
  );
  int n_chk = 0;
  int n_err = 0;
  logic [CW-1:0] exp_cnt;
  logic [STATE_W-1:0] trace[$];
  int reg_cyc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int latency(input logic [3:0] op, input int fd, input int md);
    case (op)
      OP_NOP: return 3 + fd;
      OP_BR, OP_JMP: return 4 + fd;
      OP_ALU: return 5 + fd;
      OP_STORE: return 5 + fd + md;
      OP_LOAD: return 6 + fd + md;
      default: return 0;
    endcase
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    bus.step_go = 1'b0;
    bus.step_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", bus.state, S_FETCH);
    check("rst_cnt", bus.instr_count, 0);
    check("rst_flags", {bus.halted, bus.illegal, bus.bus_err}, 0);
    check("rst_fetch_en", {bus.t_pc, bus.ld_mar, bus.mem_read}, 3'b110);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask
  task automatic run_instr(input logic [3:0] op, input logic f, input int fd, input int md,
                           input bit noise);
    logic [15:0] irv;
    int n, ep, waited, multi, n_reg, n_pc, n_wr, n_mdr;
    logic [2:0] fn_seen;
    bit strobe, prev, done;
    irv = {op, 9'($urandom), 3'($urandom)};
    bus.ir = irv;
    bus.flag = f;
    n = 0; ep = 0; waited = 0; multi = 0; n_reg = 0; n_pc = 0; n_wr = 0; n_mdr = 0;
    fn_seen = 3'd0; prev = 0; done = 0; reg_cyc = 0;
    trace.delete();
    check("start_fetch", bus.state, S_FETCH);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      strobe = bus.mem_read | bus.mem_write;
      if (strobe && !prev) begin
        ep++;
        waited = 0;
      end
      bus.mem_ack = strobe && waited == (ep == 1 ? fd : md);
      if (noise) bus.step_go = 1'($urandom);
      #1;
      if ($countones({bus.t_pc, bus.t_reg, bus.t_alu, bus.t_mdr, bus.t_label}) > 1) multi++;
      if (bus.ld_reg) begin
        n_reg++;
        reg_cyc = n + 1;
      end
      if (bus.ld_pc) n_pc++;
      if (bus.mem_write) n_wr++;
      if (bus.ld_mdr) n_mdr++;
      if (bus.t_alu) fn_seen = bus.fn_sel;
      trace.push_back(bus.state);
      if (strobe) waited++;
      prev = strobe;
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      bus.step_go = 1'b0;
      n++;
      done = bus.state == S_FETCH || bus.state == S_STEP;
    end
    check("retire_seen", 32'(done), 1);
    exp_cnt = exp_cnt + 1'b1;
    check("latency", n, latency(op, fd, md));
    check("instr_count", bus.instr_count, exp_cnt);
    check("ld_reg", n_reg, (op == OP_ALU || op == OP_LOAD) ? 1 : 0);
    check("ld_pc", n_pc, (op == OP_JMP || (op == OP_BR && f)) ? 2 : 1);
    check("mem_write", n_wr, op == OP_STORE ? md + 1 : 0);
    check("ld_mdr", n_mdr, op == OP_LOAD ? 1 : 0);
    check("one_driver", multi, 0);
    if (op == OP_ALU) check("fn_sel", fn_seen, irv[2:0]);
    check("end_state", bus.state, bus.step_en ? S_STEP : S_FETCH);
  endtask
  task automatic release_step(input bit by_go, input int idle);
    repeat (idle) @(posedge clk);
    #1;
    check("step_hold", bus.state, S_STEP);
    check("step_quiet", {bus.ld_mar, bus.t_pc, bus.mem_read, bus.mem_write}, 0);
    @(negedge clk);
    if (by_go) bus.step_go = 1'b1;
    else bus.step_en = 1'b0;
    @(posedge clk);
    #1;
    bus.step_go = 1'b0;
    check("step_release", bus.state, S_FETCH);
  endtask
  task automatic fetch_to_decode();
    @(negedge clk) bus.mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk) bus.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
  endtask
  logic [STATE_W-1:0] alu_tr[5];
  logic [3:0] ops[6];
  initial begin
    alu_tr = '{S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_WB};
    ops = '{OP_NOP, OP_ALU, OP_LOAD, OP_STORE, OP_BR, OP_JMP};
    bus.ir = '0;
    bus.flag = 1'b0;
    do_reset();
    run_instr(OP_ALU, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) check("alu_trace", trace[i], alu_tr[i]);
    check("alu_ld_reg_cycle", reg_cyc, 5);
    run_instr(OP_LOAD, 1'b0, 0, 3, 1'b0);
    run_instr(OP_BR, 1'b0, 0, 0, 1'b0);
    run_instr(OP_BR, 1'b1, 0, 0, 1'b0);
    run_instr(OP_JMP, 1'b0, 1, 0, 1'b0);
    run_instr(OP_STORE, 1'b1, 0, 2, 1'b0);
    bus.step_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_instr(OP_NOP, 1'b0, 0, 0, 1'b0);
      release_step(1'b1, 6);
    end
    bus.step_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.step_en = $urandom_range(0, 3) == 0;
      run_instr(ops[$urandom_range(0, 5)], 1'($urandom), $urandom_range(0, 4),
                $urandom_range(0, 4), 1'b1);
      if (bus.step_en) release_step(1'($urandom), $urandom_range(0, 3));
      bus.step_en = 1'b0;
    end
    run_instr(OP_NOP, 1'b0, 14, 0, 1'b0);
    check("late_ack_no_err", {bus.bus_err, bus.halted}, 0);
    bus.ir = {OP_LOAD, 12'h000};
    fetch_to_decode();
    repeat (2) @(posedge clk);
    #1;
    check("in_mrd", bus.state, S_MRD);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_state", bus.state, S_FETCH);
    check("mid_rst_cnt", bus.instr_count, 0);
    check("mid_rst_strobe", {bus.mem_read, bus.mem_write, bus.bus_err}, 0);
    do_reset();
    bus.ir = {OP_NOP, 12'h000};
    repeat (15) @(posedge clk);
    #1;
    check("wait15_still_fwait", bus.state, S_FWAIT);
    @(posedge clk);
    #1;
    check("timeout_halt", bus.state, S_HALT);
    check("timeout_flags", {bus.halted, bus.bus_err, bus.illegal}, 3'b110);
    check("timeout_no_read", bus.mem_read, 0);
    do_reset();
    bus.ir = {4'h9, 12'h000};
    fetch_to_decode();
    @(posedge clk);
    #1;
    check("illegal_flags", {bus.halted, bus.illegal, bus.bus_err}, 3'b110);
    check("illegal_cnt", bus.instr_count, 0);
    do_reset();
    bus.ir = {OP_HALT, 12'h000};
    fetch_to_decode();
    @(posedge clk);
    @(negedge clk) bus.mem_ack = 1'b1;
    bus.step_go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("halt_absorb", bus.state, S_HALT);
    check("halt_flags", {bus.halted, bus.illegal, bus.bus_err}, 3'b100);
    check("halt_quiet", {bus.ld_mar, bus.ld_ir, bus.ld_pc, bus.mem_read, bus.mem_write, bus.t_pc}, 0);
    bus.mem_ack = 1'b0;
    bus.step_go = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multi-cycle control unit for the multicycle CPU, successor to the fixed controller/state-register pair. Sequences fetch, decode, execute, memory and write-back as an FSM, drives datapath load/tristate enables, waits on a variable-latency memory handshake with timeout, and adds single-step debug mode and a retired-instruction counter. Sits beside the datapath under the CPU top level.

## Interface
- IR_W, 16, instruction width; opcode is IR[IR_W-1:IR_W-4], ALU function is IR[2:0]
- CNT_W, 16, retired-instruction counter width
- MEM_TIMEOUT, 15, max wait cycles for mem_ack before bus error (≥1)

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- ir  in  IR_W  current instruction register contents
- flag  in  1  datapath condition flag for BR
- mem_ack  in  1  memory completion, sampled only in wait states
- step_en  in  1  single-step mode enable
- step_go  in  1  one-cycle pulse releasing one instruction
- ld_mar, ld_ir, ld_pc, ld_mdr, ld_reg  out  1 each  register load enables
- pc_inc  out  1  PC increment select
- t_pc, t_reg, t_alu, t_mdr, t_label  out  1 each  bus drivers, at most one high per cycle
- mem_read, mem_write  out  1 each  memory strobes
- fn_sel  out  3  ALU function
- state  out  5  current state code
- halted, illegal, bus_err  out  1 each  status
- instr_count  out  CNT_W  retired instructions

## Operation
- Opcodes: 0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 BR, 5 JMP, F HALT; all others illegal.
- FETCH: t_pc, ld_mar → FWAIT.
- FWAIT: mem_read; on mem_ack: ld_ir, ld_pc, pc_inc → DECODE.
- DECODE: no enables; NOP → retire; ALU → EXEC; LOAD/STORE → MADDR; BR/JMP → BRANCH; HALT → HALT; illegal → HALT, set illegal.
- EXEC: t_reg, fn_sel=ir[2:0] → WB. WB: t_alu, ld_reg, fn_sel held → retire.
- MADDR: t_reg, ld_mar → MRD (LOAD) or MWR (STORE).
- MRD: mem_read; on ack ld_mdr → WBM. WBM: t_mdr, ld_reg → retire.
- MWR: mem_write, t_reg; on ack → retire.
- BRANCH: t_label and ld_pc iff JMP or flag=1 → retire.
- Retire: instr_count+1 (wraps at 2^CNT_W); next state FETCH, or STEP if step_en=1.
- STEP: no enables; step_go=1 or step_en=0 → FETCH.
- HALT: absorbing until Reset; halted=1; no enables, no strobes.
- Wait timer: counts cycles in FWAIT/MRD/MWR, cleared on entry; ack absent for MEM_TIMEOUT cycles → HALT, bus_err=1.

## Timing
- Reset (Reset=0 at edge): state=FETCH, instr_count=0, halted/illegal/bus_err=0; enables then reflect FETCH.
- Reset mid-instruction aborts it; strobes drop in the cycle after the sampling edge.
- Enables are combinational from registered state; ack-qualified enables (ld_ir, ld_pc, pc_inc, ld_mdr) are Mealy on mem_ack.
- Zero-wait latency (ack in first wait cycle): NOP 3, BR/JMP 4, ALU 5, STORE 5, LOAD 6 cycles; each ack-less cycle adds 1.
- mem_ack on the timeout cycle: ack wins, no bus_err.
- step_go outside STEP ignored; step_go and step_en=0 together → FETCH.
- status bits are sticky until Reset.

## Structure
- Package mc_pkg: opcode constants, 5-bit state codes, STATE_W, ALU fn width.
- Sub-module mc_wait_timer: clear/enable/expire counter sized by $clog2(MEM_TIMEOUT+1).
- FSM, decode and counter in mc_control_unit.

## Test plan
- Reset, then ALU with ack in first wait cycle → FETCH,FWAIT,DECODE,EXEC,WB; ld_reg in cycle 5; instr_count=1.
- LOAD with ack 3 cycles late in MRD → ld_mdr on ack cycle, 9 cycles total, single t_* driver every cycle.
- BR with flag=0 then flag=1 → ld_pc/t_label only in second BRANCH; JMP always loads.
- Withhold ack in FWAIT for 15 cycles (MEM_TIMEOUT=15) → HALT, bus_err=1, mem_read=0; ack on cycle 15 instead → no error.
- step_en=1, 3 NOPs, step_go every 10 cycles → one retire per pulse; counter 1,2,3.
- Opcode 9 → illegal=1, halted=1; Reset low mid-MRD → FETCH, count 0, flags clear.
